// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 memory responder backed by a word-addressed RAM.
// Serves one burst at a time (write or read), FIXED/INCR bursts at 32-bit
// data width, with SLVERR for out-of-range beats and illegal bursts.
// Optional feature macro: AXI_RAM_SLAVE_WRAP_EN enables WRAP bursts; without
// it every WRAP burst is answered as a burst error.
module axi_ram_slave #(
  parameter int                        AXI_ID_WIDTH   = 1,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h9000_0000
) (
  input  logic                        aclk,
  input  logic                        areset,
  // write address channel
  input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic [2:0]                  axi_awsize,
  input  logic [1:0]                  axi_awburst,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  // write data channel
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wlast,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  // write response channel
  output logic [AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  // read address channel
  input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                  axi_arlen,
  input  logic [2:0]                  axi_arsize,
  input  logic [1:0]                  axi_arburst,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  // read data channel
  output logic [AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rlast,
  output logic                        axi_rvalid,
  input  logic                        axi_rready
);

  localparam int                        IDX_W       = $clog2(MEM_DEPTH);
  localparam int                        STRB_W      = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP   = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_WORDS = AXI_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0]                RESP_OKAY   = 2'b00;
  localparam logic [1:0]                RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  // A burst is unserviceable as a whole when the beat size is not a full
  // word, the burst type is reserved, or a WRAP burst cannot be honoured.
  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [7:0] len);
    logic err;
    err = (size != 3'b010);
    case (burst)
      2'b00, 2'b01: err = err;
`ifdef AXI_RAM_SLAVE_WRAP_EN
      2'b10: err = err | !((len == 8'd1) || (len == 8'd3) ||
                           (len == 8'd7) || (len == 8'd15));
`else
      2'b10: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  state_t                    state_r;
  logic [AXI_ID_WIDTH-1:0]   id_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [7:0]                len_r;
  logic [1:0]                burst_r;
  logic [7:0]                beat_r;
  logic                      burst_err_r;
  logic                      err_r;

  logic                      bvalid_r;
  logic [1:0]                bresp_r;
  logic [AXI_ID_WIDTH-1:0]   bid_r;
  logic                      rvalid_r;
  logic                      rlast_r;
  logic [1:0]                rresp_r;
  logic [AXI_DATA_WIDTH-1:0] rdata_r;
  logic [AXI_ID_WIDTH-1:0]   rid_r;

  logic [AXI_ADDR_WIDTH-1:0] nxt_inc_s;
  logic [AXI_ADDR_WIDTH-1:0] nxt_addr_s;
`ifdef AXI_RAM_SLAVE_WRAP_EN
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask_s;
  logic [AXI_ADDR_WIDTH-1:0] nxt_wrap_s;
`endif
  logic [AXI_ADDR_WIDTH-1:0] acc_addr_s;
  logic [AXI_ADDR_WIDTH-1:0] acc_word_s;
  logic                      acc_hit_s;
  logic [IDX_W-1:0]          acc_idx_s;
  logic [AXI_DATA_WIDTH-1:0] rd_word_s;
  logic                      aw_err_s;
  logic                      ar_err_s;
  logic                      beat_burst_err_s;
  logic [AXI_DATA_WIDTH-1:0] rd_data_s;
  logic [1:0]                rd_resp_s;
  logic                      w_last_s;
  logic                      w_beat_err_s;
  logic                      mem_we_s;

  // Address of the beat after the current one, per captured burst type
  always_comb begin
    nxt_inc_s = addr_r + ADDR_STEP;
`ifdef AXI_RAM_SLAVE_WRAP_EN
    // (len+1)*4-1 is len concatenated with two ones for the legal wrap lengths
    wrap_mask_s = AXI_ADDR_WIDTH'({len_r, 2'b11});
    nxt_wrap_s  = (addr_r & ~wrap_mask_s) | (nxt_inc_s & wrap_mask_s);
`endif
    case (burst_r)
      2'b01:   nxt_addr_s = nxt_inc_s;
`ifdef AXI_RAM_SLAVE_WRAP_EN
      2'b10:   nxt_addr_s = nxt_wrap_s;
`endif
      default: nxt_addr_s = addr_r;
    endcase
  end

  // Single RAM access port: AR address in IDLE, current beat while writing,
  // next beat while reading so the R register can be refilled on handshake
  always_comb begin
    case (state_r)
      IDLE:    acc_addr_s = axi_araddr;
      WDATA:   acc_addr_s = addr_r;
      RDATA:   acc_addr_s = nxt_addr_s;
      default: acc_addr_s = addr_r;
    endcase
    acc_word_s = (acc_addr_s - BASE_ADDR) >> 2;
    acc_hit_s  = (acc_addr_s >= BASE_ADDR) && (acc_word_s < DEPTH_WORDS);
    acc_idx_s  = acc_word_s[IDX_W-1:0];
    rd_word_s  = mem_r[acc_idx_s];
  end

  // Per-beat response decode for both directions
  always_comb begin
    aw_err_s         = burst_err(axi_awsize, axi_awburst, axi_awlen);
    ar_err_s         = burst_err(axi_arsize, axi_arburst, axi_arlen);
    beat_burst_err_s = (state_r == IDLE) ? ar_err_s : burst_err_r;
    if (beat_burst_err_s || !acc_hit_s) begin
      rd_data_s = '0;
      rd_resp_s = RESP_SLVERR;
    end else begin
      rd_data_s = rd_word_s;
      rd_resp_s = RESP_OKAY;
    end
    w_last_s     = (beat_r == len_r);
    w_beat_err_s = (axi_wlast != w_last_s) || !acc_hit_s;
    mem_we_s     = (state_r == WDATA) && axi_wvalid && !burst_err_r && acc_hit_s;
  end

  // Address/data ready strobes decode the state and are held low in reset
  always_comb begin
    if (areset) begin
      axi_awready = 1'b0;
      axi_arready = 1'b0;
      axi_wready  = 1'b0;
    end else begin
      axi_awready = (state_r == IDLE);
      axi_arready = (state_r == IDLE) && !axi_awvalid;
      axi_wready  = (state_r == WDATA);
    end
  end

  // Byte-lane RAM commit; the array itself is intentionally not reset
  always_ff @(posedge aclk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (mem_we_s && axi_wstrb[b]) begin
        mem_r[acc_idx_s][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // Transaction FSM with registered B and R channel outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= IDLE;
      id_r        <= '0;
      addr_r      <= '0;
      len_r       <= 8'd0;
      burst_r     <= 2'b00;
      beat_r      <= 8'd0;
      burst_err_r <= 1'b0;
      err_r       <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      bid_r       <= '0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rresp_r     <= 2'b00;
      rdata_r     <= '0;
      rid_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (axi_awvalid) begin
            id_r        <= axi_awid;
            addr_r      <= axi_awaddr;
            len_r       <= axi_awlen;
            burst_r     <= axi_awburst;
            beat_r      <= 8'd0;
            burst_err_r <= aw_err_s;
            err_r       <= aw_err_s;
            state_r     <= WDATA;
          end else if (axi_arvalid) begin
            id_r        <= axi_arid;
            addr_r      <= axi_araddr;
            len_r       <= axi_arlen;
            burst_r     <= axi_arburst;
            beat_r      <= 8'd0;
            burst_err_r <= ar_err_s;
            err_r       <= ar_err_s;
            rvalid_r    <= 1'b1;
            rid_r       <= axi_arid;
            rdata_r     <= rd_data_s;
            rresp_r     <= rd_resp_s;
            rlast_r     <= (axi_arlen == 8'd0);
            state_r     <= RDATA;
          end else begin
            state_r     <= IDLE;
          end
        end
        WDATA: begin
          if (axi_wvalid) begin
            err_r  <= err_r | w_beat_err_s;
            addr_r <= nxt_addr_s;
            beat_r <= beat_r + 8'd1;
            if (w_last_s) begin
              bvalid_r <= 1'b1;
              bid_r    <= id_r;
              bresp_r  <= (err_r | w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
              state_r  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (axi_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RDATA: begin
          if (axi_rready) begin
            if (rlast_r) begin
              rvalid_r <= 1'b0;
              rlast_r  <= 1'b0;
              state_r  <= IDLE;
            end else begin
              addr_r  <= nxt_addr_s;
              beat_r  <= beat_r + 8'd1;
              rdata_r <= rd_data_s;
              rresp_r <= rd_resp_s;
              rlast_r <= ((beat_r + 8'd1) == len_r);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign axi_bvalid = bvalid_r;
  assign axi_bresp  = bresp_r;
  assign axi_bid    = bid_r;
  assign axi_rvalid = rvalid_r;
  assign axi_rlast  = rlast_r;
  assign axi_rresp  = rresp_r;
  assign axi_rdata  = rdata_r;
  assign axi_rid    = rid_r;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: drivers push expected B/R responses into
// queues, a monitor pops and compares them on every handshake.
module tb_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        aclk;
  logic        areset;
  logic [0:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [0:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [0:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [0:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  axi_ram_slave dut (
    .aclk(aclk), .areset(areset),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct { logic id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      exp_b [$];
  r_exp_t      exp_r [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          b_cyc   = 0;
  int          ar_cyc  = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;
  logic [31:0] wbuf [32];
  logic [31:0] blk  [32];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s: handshake never happened (t=%0t)", name, $time);
  endtask

  task automatic push_r(input logic id, input logic [31:0] data, input logic [1:0] resp, input logic last);
    exp_r.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic monitor_step();
    b_exp_t eb;
    r_exp_t er;
    cyc++;
    if (areset) begin
      hold_pend = 1'b0;
      return;
    end
    if (hold_pend) begin
      check("r_hold_data", axi_rdata, h_data);
      check("r_hold_ctl", {29'd0, axi_rvalid, axi_rlast, axi_rresp[1]}, {29'd0, 1'b1, h_last, h_resp[1]});
    end
    hold_pend = 1'b0;
    if (axi_arvalid && axi_arready) ar_cyc = cyc;
    if (axi_bvalid && axi_bready) begin
      b_cyc = cyc;
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: bresp %b with nothing expected", axi_bresp);
      end else begin
        eb = exp_b.pop_front();
        check("bid", 32'(axi_bid), 32'(eb.id));
        check("bresp", 32'(axi_bresp), 32'(eb.resp));
      end
    end
    if (axi_rvalid && axi_rready) begin
      if (exp_r.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL r_unexpected: rdata %h with nothing expected", axi_rdata);
      end else begin
        er = exp_r.pop_front();
        check("rid", 32'(axi_rid), 32'(er.id));
        check("rdata", axi_rdata, er.data);
        check("rresp", 32'(axi_rresp), 32'(er.resp));
        check("rlast", 32'(axi_rlast), 32'(er.last));
      end
    end
    if (axi_rvalid && !axi_rready) begin
      hold_pend = 1'b1;
      h_data = axi_rdata;
      h_resp = axi_rresp;
      h_last = axi_rlast;
    end
  endtask

  task automatic write_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                             input bit wlast_ok, input logic [1:0] exp_resp);
    int guard;
    exp_b.push_back('{id: id, resp: exp_resp});
    axi_awid = id; axi_awaddr = addr; axi_awlen = len;
    axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!axi_awready) begin
      guard++;
      if (guard > 200) begin report_timeout("aw_handshake"); axi_awvalid = 1'b0; return; end
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi_wdata = wbuf[i]; axi_wstrb = strb;
      axi_wlast = wlast_ok && (i == int'(len));
      axi_wvalid = 1'b1;
      guard = 0;
      @(negedge aclk);
      while (!axi_wready) begin
        guard++;
        if (guard > 200) begin report_timeout("w_handshake"); axi_wvalid = 1'b0; return; end
        @(negedge aclk);
      end
      @(posedge aclk); #1;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!axi_bvalid) begin
      guard++;
      if (guard > 200) begin report_timeout("b_handshake"); axi_bready = 1'b0; return; end
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic read_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int guard;
    bit done;
    axi_arid = id; axi_araddr = addr; axi_arlen = len;
    axi_arsize = size; axi_arburst = burst; axi_arvalid = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!axi_arready) begin
      guard++;
      if (guard > 200) begin report_timeout("ar_handshake"); axi_arvalid = 1'b0; return; end
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    axi_arvalid = 1'b0;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (axi_rvalid && axi_rready && axi_rlast) done = 1'b1;
      guard++;
      if (!done && guard > 400) begin report_timeout("r_last"); axi_rready = 1'b0; return; end
      @(posedge aclk); #1;
    end
    axi_rready = 1'b0;
  endtask

  task automatic run_all();
    // reset state
    areset = 1'b1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b0;
    axi_arvalid = 1'b0; axi_rready = 1'b0;
    axi_awid = 1'b0; axi_awaddr = 32'd0; axi_awlen = 8'd0; axi_awsize = 3'd2; axi_awburst = 2'b01;
    axi_wdata = 32'd0; axi_wstrb = 4'h0;
    axi_arid = 1'b0; axi_araddr = 32'd0; axi_arlen = 8'd0; axi_arsize = 3'd2; axi_arburst = 2'b01;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_readies", {29'd0, axi_awready, axi_arready, axi_wready}, 32'd0);
    check("rst_valids", {29'd0, axi_bvalid, axi_rvalid, axi_rlast}, 32'd0);
    check("rst_resp_ids", {26'd0, axi_bresp, axi_rresp, axi_bid, axi_rid}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("idle_readies", {30'd0, axi_awready, axi_arready}, 32'd3);
    @(posedge aclk); #1;

    // 32-beat INCR write and readback
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = 32'h6434_3962 + 32'h0101_0101 * 32'(i);
      blk[i]  = wbuf[i];
    end
    write_burst(1'b1, BASE, 8'd31, 3'd2, 2'b01, 4'hF, 1'b1, 2'b00);
    for (int i = 0; i < 32; i++) push_r(1'b1, blk[i], 2'b00, i == 31);
    read_burst(1'b1, BASE, 8'd31, 3'd2, 2'b01, 1'b0);

    // FIXED burst leaves the last beat in one word
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_burst(1'b0, BASE + 32'h10, 8'd3, 3'd2, 2'b00, 4'hF, 1'b1, 2'b00);
    blk[4] = 32'h0000_0004;
    push_r(1'b0, 32'h0000_0004, 2'b00, 1'b1);
    read_burst(1'b0, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    // WRAP len 3 starting mid-window
    wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B;
    wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
`ifdef AXI_RAM_SLAVE_WRAP_EN
    write_burst(1'b0, BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'hF, 1'b1, 2'b00);
    blk[0] = 32'hCCCC_000C; blk[1] = 32'hDDDD_000D;
    blk[2] = 32'hAAAA_000A; blk[3] = 32'hBBBB_000B;
`else
    write_burst(1'b0, BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'hF, 1'b1, 2'b10);
`endif
    for (int i = 0; i < 4; i++) push_r(1'b0, blk[i], 2'b00, i == 3);
    read_burst(1'b0, BASE, 8'd3, 3'd2, 2'b01, 1'b0);

    // below the base address
    wbuf[0] = 32'h1234_5678;
    write_burst(1'b0, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 4'hF, 1'b1, 2'b10);
    push_r(1'b0, 32'h0000_0000, 2'b10, 1'b1);
    read_burst(1'b0, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 1'b0);

    // bad size: write ignored, read returns zero/SLVERR on every beat
    wbuf[0] = 32'hDEAD_0001; wbuf[1] = 32'hDEAD_0002;
    write_burst(1'b0, BASE + 32'h40, 8'd1, 3'd1, 2'b01, 4'hF, 1'b1, 2'b10);
    push_r(1'b0, blk[16], 2'b00, 1'b0);
    push_r(1'b0, blk[17], 2'b00, 1'b1);
    read_burst(1'b0, BASE + 32'h40, 8'd1, 3'd2, 2'b01, 1'b0);
    push_r(1'b1, 32'h0, 2'b10, 1'b0);
    push_r(1'b1, 32'h0, 2'b10, 1'b1);
    read_burst(1'b1, BASE, 8'd1, 3'd1, 2'b01, 1'b0);

    // missing wlast: SLVERR but data still committed
    wbuf[0] = 32'h1357_9BDF; wbuf[1] = 32'h2468_ACE0;
    write_burst(1'b1, BASE + 32'h50, 8'd1, 3'd2, 2'b01, 4'hF, 1'b0, 2'b10);
    blk[20] = 32'h1357_9BDF; blk[21] = 32'h2468_ACE0;
    push_r(1'b1, blk[20], 2'b00, 1'b0);
    push_r(1'b1, blk[21], 2'b00, 1'b1);
    read_burst(1'b1, BASE + 32'h50, 8'd1, 3'd2, 2'b01, 1'b0);

    // last word then one beyond the top of the RAM
    wbuf[0] = 32'hFEED_0FF0;
    write_burst(1'b0, BASE + 32'h3FC, 8'd0, 3'd2, 2'b01, 4'hF, 1'b1, 2'b00);
    push_r(1'b0, 32'hFEED_0FF0, 2'b00, 1'b0);
    push_r(1'b0, 32'h0000_0000, 2'b10, 1'b1);
    read_burst(1'b0, BASE + 32'h3FC, 8'd1, 3'd2, 2'b01, 1'b0);

    // reserved burst type
    push_r(1'b0, 32'h0000_0000, 2'b10, 1'b1);
    read_burst(1'b0, BASE, 8'd0, 3'd2, 2'b11, 1'b0);

    // simultaneous AW and AR: write completes first, read sees new data
    wbuf[0] = 32'h5A5A_1234;
    push_r(1'b1, 32'h5A5A_1234, 2'b00, 1'b1);
    fork
      write_burst(1'b0, BASE + 32'hA0, 8'd0, 3'd2, 2'b01, 4'hF, 1'b1, 2'b00);
      read_burst(1'b1, BASE + 32'hA0, 8'd0, 3'd2, 2'b01, 1'b0);
    join
    check("ar_after_b", 32'(ar_cyc > b_cyc), 32'd1);

    // partial strobes
    wbuf[0] = 32'h1122_3344;
    write_burst(1'b0, BASE + 32'hC0, 8'd0, 3'd2, 2'b01, 4'hF, 1'b1, 2'b00);
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(1'b0, BASE + 32'hC0, 8'd0, 3'd2, 2'b01, 4'b0011, 1'b1, 2'b00);
    push_r(1'b0, 32'h1122_CCDD, 2'b00, 1'b1);
    read_burst(1'b0, BASE + 32'hC0, 8'd0, 3'd2, 2'b01, 1'b0);

    // 8-beat read with random rready stalls
    for (int i = 0; i < 8; i++) push_r(1'b1, blk[i], 2'b00, i == 7);
    read_burst(1'b1, BASE, 8'd7, 3'd2, 2'b01, 1'b1);

    // reset in the middle of a read burst
    axi_arid = 1'b1; axi_araddr = BASE; axi_arlen = 8'd7;
    axi_arsize = 3'd2; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    @(negedge aclk);
    check("pre_reset_arready", 32'(axi_arready), 32'd1);
    @(posedge aclk); #1;
    axi_arvalid = 1'b0;
    @(negedge aclk);
    check("mid_read_rdata", axi_rdata, blk[0]);
    @(posedge aclk); #3;
    areset = 1'b1;
    #1;
    check("mid_rst_r", {30'd0, axi_rvalid, axi_rlast}, 32'd0);
    check("mid_rst_rdata", axi_rdata, 32'd0);
    check("mid_rst_readies", {29'd0, axi_awready, axi_arready, axi_wready}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_idle", {29'd0, axi_awready, axi_arready, axi_rvalid}, 32'd6);
    @(posedge aclk); #1;

    check("exp_b_drained", 32'(exp_b.size()), 32'd0);
    check("exp_r_drained", 32'(exp_r.size()), 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge aclk);
          monitor_step();
        end
      end
      begin
        run_all();
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
